// File: rtl/uart_rx_if.sv
// Serial receive bundle: the raw line in, received byte and status out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    // Line driver / byte consumer side
    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );

    // Receiver side
    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM,
// one-cycle rx_valid / frame_err pulses, break-safe wait for idle line.
module uart_rx #(
    parameter int CLK_FREQ = 1_000_000,
    parameter int BAUD     = 9600
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [7:0]        rx_data_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    logic              rx_busy_q;
    logic              rx_meta_q;
    logic              rx_s_q;

    // Two-stage synchronizer for the asynchronous line; resets to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM with bit-period counter and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q     <= CNT_ZERO;
                    bit_idx_q <= 3'd0;
                    if (!rx_s_q) begin
                        state_q   <= START;
                        rx_busy_q <= 1'b1;
                    end else begin
                        rx_busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF_LAST) begin
                        cnt_q <= CNT_ZERO;
                        if (!rx_s_q) begin
                            state_q   <= DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            // Glitch shorter than half a bit: drop it silently
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_q              <= CNT_ZERO;
                        shift_q[bit_idx_q] <= rx_s_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_q <= CNT_ZERO;
                        if (rx_s_q) begin
                            // Leave at mid-stop so a directly following start bit is caught
                            rx_data_q  <= shift_q;
                            rx_valid_q <= 1'b1;
                            state_q    <= IDLE;
                            rx_busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low (break) line must not be mistaken for new start bits
                    if (rx_s_q) begin
                        state_q   <= IDLE;
                        rx_busy_q <= 1'b0;
                    end else begin
                        rx_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= CNT_ZERO;
                    bit_idx_q <= 3'd0;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = rx_busy_q;

endmodule
